// File: rtl/mips_dmem_responder.sv
// mips_dmem_responder: wait-state data memory for the MEM stage; Req_Read/Req_Write/Address/Write_Data in, Read_Data/Ready/Error out, Mem_Stall pipeline freeze, Stall_Cycles saturating stall count
module mips_dmem_responder #(
  parameter int DEPTH = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req_Read,
  input  logic        Req_Write,
  input  logic [31:0] Address,
  input  logic [31:0] Write_Data,
  output logic [31:0] Read_Data,
  output logic        Ready,
  output logic        Error,
  output logic        Mem_Stall,
  output logic [31:0] Stall_Cycles
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic rd_q, wr_q, req, go, fault, cur_rd, cur_wr;
  logic [31:0] addr_q, data_q, cur_addr, cur_data;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH];
  always_comb begin
    req = Req_Read | Req_Write;
    cur_rd = (state == IDLE) ? Req_Read : rd_q;
    cur_wr = (state == IDLE) ? Req_Write : wr_q;
    cur_addr = (state == IDLE) ? Address : addr_q;
    cur_data = (state == IDLE) ? Write_Data : data_q;
    idx = cur_addr[AW+1:2];
    fault = (cur_addr[1:0] != 2'b00) | (cur_addr[31:AW+2] != '0) | (cur_rd & cur_wr);
    state_nxt = (state == IDLE) ? (req ? ((WAIT_STATES == 0) ? RESP : WAIT) : IDLE) :
                (state == WAIT) ? (!req ? IDLE : (cnt == 4'd1) ? RESP : WAIT) : IDLE;
    go = state_nxt == RESP;
    Mem_Stall = req & ~Ready;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      addr_q <= 32'd0;
      data_q <= 32'd0;
      Read_Data <= 32'd0;
      Ready <= 1'b0;
      Error <= 1'b0;
      Stall_Cycles <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt <= (state == IDLE) ? 4'(WAIT_STATES) : cnt - 4'd1;
      if (state == IDLE) begin
        rd_q <= Req_Read;
        wr_q <= Req_Write;
        addr_q <= Address;
        data_q <= Write_Data;
      end
      Ready <= go;
      Error <= go & fault;
      if (go & cur_rd & ~fault) Read_Data <= mem[idx];
      if (Mem_Stall && Stall_Cycles != '1) Stall_Cycles <= Stall_Cycles + 32'd1;
    end
  end
  always_ff @(posedge Clk) if (!Reset && go && cur_wr && !fault) mem[idx] <= cur_data;
endmodule

// File: tb/tb_mips_dmem_responder.sv
// tb_mips_dmem_responder: randomized and directed checks of two responders (2 and 0 wait states) against a transaction-level model
module tb_mips_dmem_responder;
  localparam int DEPTH = 256;
  logic clk;
  logic rst [2], rd [2], wr [2], ready [2], err [2], stall [2];
  logic [31:0] addr [2], wd [2], rdata [2], scnt [2];
  bit run, preset [2];
  int n_chk, n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %h expected %h at %0t", nm, g, act, exp, $time);
    end
  endtask

  function automatic bit fault_of(input logic r, input logic w, input logic [31:0] a);
    return (a % 4 != 0) || (a >= 4 * DEPTH) || (r && w);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int W = (g == 0) ? 2 : 0;
    mips_dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(W)) dut (
      .Clk(clk), .Reset(rst[g]), .Req_Read(rd[g]), .Req_Write(wr[g]),
      .Address(addr[g]), .Write_Data(wd[g]), .Read_Data(rdata[g]), .Ready(ready[g]),
      .Error(err[g]), .Mem_Stall(stall[g]), .Stall_Cycles(scnt[g]));
    logic [31:0] m_mem [DEPTH];
    bit m_val [DEPTH];
    bit busy, e_ready, e_err, e_rval;
    int age;
    logic c_rd, c_wr, req, go, a_rd, a_wr, flt;
    logic [31:0] c_a, c_d, a_a, a_d, e_rdata, e_cnt;
    // a request completes W edges after it is first seen idle, unless dropped
    always_comb begin
      req = rd[g] | wr[g];
      go = !rst[g] && ((!e_ready && !busy && req && W == 0) || (busy && req && age + 1 == W));
      a_rd = busy ? c_rd : rd[g];
      a_wr = busy ? c_wr : wr[g];
      a_a = busy ? c_a : addr[g];
      a_d = busy ? c_d : wd[g];
      flt = fault_of(a_rd, a_wr, a_a);
    end
    always @(posedge clk) begin
      if (rst[g]) begin
        busy <= 1'b0;
        e_ready <= 1'b0;
        e_err <= 1'b0;
        e_rdata <= 32'd0;
        e_rval <= 1'b1;
        e_cnt <= 32'd0;
        age <= 0;
      end else begin
        if (preset[g]) e_cnt <= 32'hFFFF_FFFE;
        else if (req && !e_ready && e_cnt != 32'hFFFF_FFFF) e_cnt <= e_cnt + 32'd1;
        e_ready <= go;
        e_err <= go && flt;
        if (!e_ready && !busy && req) begin
          c_rd <= rd[g];
          c_wr <= wr[g];
          c_a <= addr[g];
          c_d <= wd[g];
          age <= 0;
          busy <= (W != 0);
        end else if (busy) begin
          busy <= req && (age + 1 != W);
          age <= age + 1;
        end
        if (go && !flt && a_wr) begin
          m_mem[a_a[9:2]] <= a_d;
          m_val[a_a[9:2]] <= 1'b1;
        end
        if (go && !flt && a_rd) begin
          e_rdata <= m_mem[a_a[9:2]];
          e_rval <= m_val[a_a[9:2]];
        end
      end
    end
    always @(negedge clk) if (run) begin
      chk("ready", g, 32'(ready[g]), 32'(e_ready));
      chk("error", g, 32'(err[g]), 32'(e_err));
      chk("mem_stall", g, 32'(stall[g]), 32'((rd[g] | wr[g]) & ~e_ready));
      if (!preset[g]) chk("stall_cycles", g, scnt[g], e_cnt);
      if (e_rval) chk("read_data", g, rdata[g], e_rdata);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // drives one request from the current cycle (cycle 0); lat = cycle of Ready or -1
  task automatic xact(input int g, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input int drop, input int rst_at, output int lat);
    int lim;
    rd[g] = r;
    wr[g] = w;
    addr[g] = a;
    wd[g] = d;
    lat = -1;
    lim = 40;
    for (int k = 0; k < lim && lat < 0; k++) begin
      cyc(1);
      rst[g] = 1'b0;
      if (ready[g]) lat = k + 1;
      else if (k + 1 == drop || k + 1 == rst_at) begin
        rd[g] = 1'b0;
        wr[g] = 1'b0;
        rst[g] = (k + 1 == rst_at);
        lim = k + 4;
      end
    end
    rd[g] = 1'b0;
    wr[g] = 1'b0;
  endtask

  initial begin
    int lat, wv, kind, drop, ra;
    logic [31:0] a;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = 32'd0; wd[i] = 32'd0; preset[i] = 1'b0;
    end
    cyc(1);
    run = 1'b1;
    cyc(1);
    for (int i = 0; i < 2; i++) rst[i] = 1'b0;
    for (int g = 0; g < 2; g++) begin
      wv = (g == 0) ? 2 : 0;
      chk("reset_read_data", g, rdata[g], 32'd0);
      chk("reset_stall_cycles", g, scnt[g], 32'd0);
      chk("reset_ready", g, 32'(ready[g]), 32'd0);
      cyc(1);
      xact(g, 0, 1, 32'h10, 32'hDEADBEEF, 0, 0, lat);
      chk("write_latency", g, lat, wv + 1);
      cyc(1);
      xact(g, 1, 0, 32'h10, 32'd0, 0, 0, lat);
      chk("read_latency", g, lat, wv + 1);
      chk("read_deadbeef", g, rdata[g], 32'hDEADBEEF);
      chk("stall_after_wr_rd", g, scnt[g], 32'(2 * (wv + 1)));
      cyc(1);
      xact(g, 0, 1, 32'h0, 32'd1, 0, 0, lat);
      xact(g, 0, 1, 32'h4, 32'd2, 0, 0, lat);
      cyc(1);
      xact(g, 1, 0, 32'h0, 32'd0, 0, 0, lat);
      chk("b2b_first", g, rdata[g], 32'd1);
      xact(g, 1, 0, 32'h4, 32'd0, 0, 0, lat);
      chk("b2b_period", g, lat, wv + 2);
      chk("b2b_second", g, rdata[g], 32'd2);
      cyc(1);
      xact(g, 1, 0, 32'h6, 32'd0, 0, 0, lat);
      chk("misaligned_latency", g, lat, wv + 1);
      chk("misaligned_error", g, 32'(err[g]), 32'd1);
      chk("misaligned_data_held", g, rdata[g], 32'd2);
      cyc(1);
      xact(g, 0, 1, 32'h400, 32'h55, 0, 0, lat);
      chk("range_error", g, 32'(err[g]), 32'd1);
      cyc(1);
      xact(g, 1, 0, 32'h0, 32'd0, 0, 0, lat);
      chk("range_no_write", g, rdata[g], 32'd1);
      cyc(1);
      xact(g, 1, 1, 32'h0, 32'h99, 0, 0, lat);
      chk("both_error", g, 32'(err[g]), 32'd1);
      cyc(1);
      xact(g, 1, 0, 32'h0, 32'd0, 0, 0, lat);
      chk("both_no_write", g, rdata[g], 32'd1);
      if (wv == 2) begin
        cyc(1);
        xact(g, 0, 1, 32'h20, 32'hA5, 0, 0, lat);
        cyc(1);
        xact(g, 0, 1, 32'h20, 32'h77, 1, 0, lat);
        chk("abort_no_ready", g, lat, -1);
        xact(g, 1, 0, 32'h20, 32'd0, 0, 0, lat);
        chk("abort_old_value", g, rdata[g], 32'hA5);
        cyc(1);
        rd[g] = 1'b1;
        addr[g] = 32'h0;
        cyc(2);
        rst[g] = 1'b1;
        cyc(1);
        rst[g] = 1'b0;
        rd[g] = 1'b0;
        chk("reset_mid_ready", g, 32'(ready[g]), 32'd0);
        chk("reset_mid_stall", g, scnt[g], 32'd0);
        cyc(3);
        chk("reset_mid_no_late_ready", g, 32'(ready[g]), 32'd0);
        xact(g, 1, 0, 32'h10, 32'd0, 0, 0, lat);
        chk("mem_kept_over_reset", g, rdata[g], 32'hDEADBEEF);
        cyc(1);
        force inst[0].dut.Stall_Cycles = 32'hFFFF_FFFE;
        preset[g] = 1'b1;
        #1 release inst[0].dut.Stall_Cycles;
        cyc(1);
        preset[g] = 1'b0;
        xact(g, 1, 0, 32'h0, 32'd0, 0, 0, lat);
        chk("saturate", g, scnt[g], 32'hFFFF_FFFF);
        cyc(1);
        xact(g, 1, 0, 32'h0, 32'd0, 0, 0, lat);
        chk("saturate_hold", g, scnt[g], 32'hFFFF_FFFF);
      end
      repeat (150) begin
        cyc($urandom_range(0, 2));
        kind = $urandom_range(0, 9);
        a = 32'($urandom_range(0, 31)) * 4;
        if ($urandom_range(0, 9) == 0) a = a | 32'h2;
        if ($urandom_range(0, 9) == 0) a = a + 32'h400;
        drop = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
        ra = ($urandom_range(0, 15) == 0) ? $urandom_range(1, 3) : 0;
        xact(g, kind < 4 || kind >= 8, kind >= 4, a, $urandom, drop, ra, lat);
      end
      cyc(2);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
